// File: rtl/rx_rate_change_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_rate_change_sequencer                                      |
// | Description : Orders a receive-side speed change across the RX datapath:    |
// |               drain -> wait PhyStatus -> commit GEN + LFSR reseed ->        |
// |               wait lane re-alignment -> release. Owns the datapath GEN.     |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module rx_rate_change_sequencer #(
  parameter int         MAX_LANES     = 16,
  parameter int         DRAIN_CYCLES  = 4,
  parameter int         PHY_TIMEOUT   = 1024,
  parameter int         ALIGN_TIMEOUT = 256,
  parameter logic [2:0] RESET_GEN     = 3'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rate_change_req,
  input  logic [2:0]           target_gen,
  input  logic [4:0]           numberOfDetectedLanes,
  input  logic [MAX_LANES-1:0] PhyStatus,
  input  logic [MAX_LANES-1:0] RxValid,
  input  logic [MAX_LANES-1:0] RxStartBlock,
  input  logic                 lmc_valid,
  output logic [2:0]           GEN,
  output logic                 datapath_hold,
  output logic                 descrambler_reset,
  output logic                 rate_change_done,
  output logic                 rate_change_fail,
  output logic                 busy,
  output logic [2:0]           seq_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAIN    = 3'd1,
    S_WAIT_PHY = 3'd2,
    S_RECONFIG = 3'd3,
    S_ALIGN    = 3'd4,
    S_DONE     = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  // One timer serves both WAIT_PHY and ALIGN, sized for the longer of the two.
  localparam int c_TMR_MAX = (PHY_TIMEOUT > ALIGN_TIMEOUT) ? PHY_TIMEOUT : ALIGN_TIMEOUT;
  localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
  localparam logic [c_TMR_W-1:0] c_PHY_LAST   = c_TMR_W'(PHY_TIMEOUT - 1);
  localparam logic [c_TMR_W-1:0] c_ALIGN_LAST = c_TMR_W'(ALIGN_TIMEOUT - 1);
  // Drain exits on the cycle that completes DRAIN_CYCLES idle cycles.
  localparam logic [2:0]         c_DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
  localparam logic [5:0]         c_LANES      = 6'(MAX_LANES);

  state_t                 r_state;
  logic [2:0]             r_gen;
  logic [2:0]             r_prev_gen;
  logic [2:0]             r_target;
  logic [MAX_LANES-1:0]   r_mask;
  logic [MAX_LANES-1:0]   r_seen;
  logic [2:0]             r_drain_cnt;
  logic [c_TMR_W-1:0]     r_tmr;
  logic                   r_hold;
  logic                   r_desc_rst;
  logic                   r_done;
  logic                   r_fail;
  logic                   r_busy;

  logic [5:0]             w_lane_cnt;
  logic [MAX_LANES-1:0]   w_mask;
  logic [MAX_LANES-1:0]   w_align_ind;
  logic                   w_target_legal;
  logic                   w_phy_all;
  logic                   w_align_all;

  // Active lane mask from the detected lane count (0 -> 1 lane, saturate at MAX_LANES).
  always_comb begin
    w_lane_cnt = {1'b0, numberOfDetectedLanes};
    if (w_lane_cnt == 6'd0) begin
      w_lane_cnt = 6'd1;
    end else if (w_lane_cnt > c_LANES) begin
      w_lane_cnt = c_LANES;
    end
    w_mask = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      w_mask[i] = (6'(i) < w_lane_cnt);
    end
  end

  // Alignment indication follows the already-committed GEN; completion checks include this cycle's inputs.
  always_comb begin
    w_target_legal = (target_gen >= 3'd1) && (target_gen <= 3'd5);
    w_align_ind    = (r_gen >= 3'd3) ? (RxStartBlock & RxValid) : RxValid;
    w_phy_all      = (((r_seen | PhyStatus) & r_mask) == r_mask);
    w_align_all    = (((r_seen | w_align_ind) & r_mask) == r_mask);
  end

  // Sequencer: state, counters, sticky lane collectors and every registered output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_gen       <= RESET_GEN;
      r_prev_gen  <= RESET_GEN;
      r_target    <= RESET_GEN;
      r_mask      <= '0;
      r_seen      <= '0;
      r_drain_cnt <= '0;
      r_tmr       <= '0;
      r_hold      <= 1'b0;
      r_desc_rst  <= 1'b0;
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_desc_rst <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (rate_change_req) begin
            r_busy     <= 1'b1;
            r_prev_gen <= r_gen;
            if (!w_target_legal) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else if (target_gen == r_gen) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_target    <= target_gen;
              r_mask      <= w_mask;
              r_drain_cnt <= '0;
              r_state     <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (lmc_valid) begin
            r_drain_cnt <= '0;
          end else if (r_drain_cnt == c_DRAIN_LAST) begin
            r_state <= S_WAIT_PHY;
            r_hold  <= 1'b1;
            r_seen  <= '0;
            r_tmr   <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 3'd1;
          end
        end
        S_WAIT_PHY: begin
          if (w_phy_all) begin
            r_state    <= S_RECONFIG;
            r_desc_rst <= 1'b1;
          end else if (r_tmr == c_PHY_LAST) begin
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
            r_gen   <= r_prev_gen;
          end else begin
            r_seen <= r_seen | (PhyStatus & r_mask);
            r_tmr  <= r_tmr + 1'b1;
          end
        end
        S_RECONFIG: begin
          r_gen   <= r_target;
          r_seen  <= '0;
          r_tmr   <= '0;
          r_state <= S_ALIGN;
        end
        S_ALIGN: begin
          if (w_align_all) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (r_tmr == c_ALIGN_LAST) begin
            // Undo the GEN committed in RECONFIG.
            r_state <= S_FAIL;
            r_fail  <= 1'b1;
            r_gen   <= r_prev_gen;
          end else begin
            r_seen <= r_seen | (w_align_ind & r_mask);
            r_tmr  <= r_tmr + 1'b1;
          end
        end
        S_DONE, S_FAIL: begin
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_hold  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign GEN               = r_gen;
  assign datapath_hold     = r_hold;
  assign descrambler_reset = r_desc_rst;
  assign rate_change_done  = r_done;
  assign rate_change_fail  = r_fail;
  assign busy              = r_busy;
  assign seq_state         = r_state;

endmodule
`default_nettype wire
